// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer.
//   seq_state_e      : sequencer FSM state encoding
//   PC_INC           : sequential fetch stride in bytes
//   RESET_PC_DEFAULT : default PC loaded on reset
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } seq_state_e;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_select.sv
// Combinational priority pick of the redirect target.
// Priority jr > jmp > beq; lower-priority targets are ignored when a higher one is asserted.
//   jr, jmp, beq       : redirect requests
//   PCreg, PCjmp,
//   PCbranch           : matching target addresses
//   redir              : any redirect requested
//   tgt                : winning target
module next_pc_select #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              jr,
    input  logic              jmp,
    input  logic              beq,
    input  logic [ADDR_W-1:0] PCreg,
    input  logic [ADDR_W-1:0] PCjmp,
    input  logic [ADDR_W-1:0] PCbranch,
    output logic              redir,
    output logic [ADDR_W-1:0] tgt
);

    always_comb begin
        redir = jr | jmp | beq;
        if (jr) begin
            tgt = PCreg;
        end else if (jmp) begin
            tgt = PCjmp;
        end else begin
            tgt = PCbranch;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC register sequenced against the instruction-memory handshake.
// A redirect arriving while a fetch is in flight is parked in pend_pc until the
// wrong-path fetch completes; that response is marked invalid.
//   clk, rst_n          : clock, async active-low reset
//   stall               : hazard unit, do not start a new fetch
//   beq/jmp/jr + targets: redirect sources (priority jr > jmp > beq)
//   imem_ready          : IMEM accepts the request this cycle
//   imem_req            : fetch request
//   pc, pc_plus4        : fetch address and its successor
//   fetch_valid         : accepted fetch is on the correct path
//   flush_ifid          : kill IF/ID this cycle
//   misalign            : sticky misaligned-target fault
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              beq,
    input  logic [ADDR_W-1:0] PCbranch,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] PCjmp,
    input  logic              jr,
    input  logic [ADDR_W-1:0] PCreg,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_valid,
    output logic              flush_ifid,
    output logic              misalign
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              req_hold_q, req_hold_d;
    logic              misalign_q, misalign_d;

    logic              redir;
    logic [ADDR_W-1:0] tgt;
    logic              tgt_bad;
    logic              accept;
    logic [ADDR_W-1:0] hold_tgt;

    next_pc_select #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_select (
        .jr       (jr),
        .jmp      (jmp),
        .beq      (beq),
        .PCreg    (PCreg),
        .PCjmp    (PCjmp),
        .PCbranch (PCbranch),
        .redir    (redir),
        .tgt      (tgt)
    );

    assign tgt_bad  = (tgt[1:0] != 2'b00);
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + ADDR_W'(PC_INC);
    assign misalign = misalign_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            req_hold_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            req_hold_q <= req_hold_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        misalign_d = misalign_q;
        req_hold_d = imem_req & ~imem_ready;
        // A redirect in S_HOLD replaces the parked target (last writer wins).
        hold_tgt   = redir ? tgt : pend_pc_q;

        case (state_q)
            S_RUN: begin
                if (redir) begin
                    // Misaligned targets are caught at capture so they can never reach pc.
                    if (tgt_bad) begin
                        misalign_d = 1'b1;
                        state_d    = S_FAULT;
                    end else if (!req_hold_q && !accept) begin
                        pc_d = tgt;
                    end else begin
                        pend_pc_d = tgt;
                        state_d   = S_HOLD;
                    end
                end else if (accept) begin
                    pc_d = pc_plus4;
                end
            end
            S_HOLD: begin
                if (redir && tgt_bad) begin
                    misalign_d = 1'b1;
                    state_d    = S_FAULT;
                end else if (accept) begin
                    pc_d    = hold_tgt;
                    state_d = S_RUN;
                end else begin
                    pend_pc_d = hold_tgt;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem_req = 1'b0;
        case (state_q)
            // A fresh redirect with nothing in flight suppresses the request so the
            // new target is fetched next cycle instead of the stale pc.
            S_RUN:   imem_req = (req_hold_q | ~stall) & ~(redir & ~req_hold_q);
            S_HOLD:  imem_req = req_hold_q | ~stall;
            default: imem_req = 1'b0;
        endcase
        accept      = imem_req & imem_ready;
        fetch_valid = accept & (state_q == S_RUN) & ~redir;
        flush_ifid  = redir & (state_q != S_FAULT);
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        beq;
    logic [31:0] PCbranch;
    logic        jmp;
    logic [31:0] PCjmp;
    logic        jr;
    logic [31:0] PCreg;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush_ifid;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .beq         (beq),
        .PCbranch    (PCbranch),
        .jmp         (jmp),
        .PCjmp       (PCjmp),
        .jr          (jr),
        .PCreg       (PCreg),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .flush_ifid  (flush_ifid),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redir();
        beq = 1'b0;
        jmp = 1'b0;
        jr  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        PCbranch   = '0;
        PCjmp      = '0;
        PCreg      = '0;
        clear_redir();

        // Reset state
        #2;
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
        check_eq("rst_flush", {31'd0, flush_ifid}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;

        // 1: sequential fetch
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_pc", pc, 32'(4 * i));
            check_eq("seq_fv", {31'd0, fetch_valid}, 32'd1);
            check_eq("seq_flush", {31'd0, flush_ifid}, 32'd0);
            tick();
        end
        check_eq("seq_pc_end", pc, 32'h10);

        // 2: beq + jmp same cycle, jmp wins, no fetch in flight
        beq = 1'b1; PCbranch = 32'h40;
        jmp = 1'b1; PCjmp    = 32'h80;
        #1;
        check_eq("prio_flush", {31'd0, flush_ifid}, 32'd1);
        check_eq("prio_req", {31'd0, imem_req}, 32'd0);
        check_eq("prio_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        clear_redir();
        #1;
        check_eq("prio_pc", pc, 32'h80);

        // wrap of pc_plus4
        jmp = 1'b1; PCjmp = 32'hFFFF_FFFC;
        tick();
        clear_redir();
        #1;
        check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        check_eq("wrap_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        check_eq("wrap_next", pc, 32'h0);

        // jr beats jmp and beq
        jr = 1'b1; PCreg = 32'h20;
        jmp = 1'b1; PCjmp = 32'h80;
        beq = 1'b1; PCbranch = 32'h40;
        tick();
        clear_redir();
        #1;
        check_eq("jr_prio_pc", pc, 32'h20);

        // 3: jr while a request is in flight
        imem_ready = 1'b0;
        #1;
        check_eq("inflight_req0", {31'd0, imem_req}, 32'd1);
        tick();
        jr = 1'b1; PCreg = 32'h100;
        #1;
        check_eq("inflight_flush", {31'd0, flush_ifid}, 32'd1);
        check_eq("inflight_req1", {31'd0, imem_req}, 32'd1);
        tick();
        clear_redir();
        #1;
        check_eq("hold_pc", pc, 32'h20);
        check_eq("hold_req", {31'd0, imem_req}, 32'd1);
        tick();
        imem_ready = 1'b1;
        #1;
        check_eq("hold_pc2", pc, 32'h20);
        check_eq("hold_accept_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check_eq("hold_done_pc", pc, 32'h100);
        check_eq("run_again_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        check_eq("run_again_pc", pc, 32'h104);

        // 4: stall cannot withdraw a pending request
        imem_ready = 1'b0;
        tick();
        stall = 1'b1;
        #1;
        check_eq("stall_req_held", {31'd0, imem_req}, 32'd1);
        tick();
        imem_ready = 1'b1;
        #1;
        check_eq("stall_req_acc", {31'd0, imem_req}, 32'd1);
        check_eq("stall_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        check_eq("stall_req_drop", {31'd0, imem_req}, 32'd0);
        check_eq("stall_fv_drop", {31'd0, fetch_valid}, 32'd0);
        tick();
        check_eq("stall_pc", pc, 32'h108);
        check_eq("stall_plus4", pc_plus4, 32'h10C);

        // 6: reset while in S_HOLD discards the pending target
        stall = 1'b0;
        imem_ready = 1'b0;
        tick();
        jmp = 1'b1; PCjmp = 32'h200;
        tick();
        clear_redir();
        #1;
        check_eq("pre_rst_pc", pc, 32'h108);
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        imem_ready = 1'b1;
        #1;
        check_eq("postrst_pc0", pc, 32'h0);
        check_eq("postrst_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        check_eq("postrst_pc1", pc, 32'h4);
        tick();
        check_eq("postrst_pc2", pc, 32'h8);

        // 5: misaligned jump target -> sticky fault
        jmp = 1'b1; PCjmp = 32'h42;
        #1;
        check_eq("mis_flush", {31'd0, flush_ifid}, 32'd1);
        check_eq("mis_req_same", {31'd0, imem_req}, 32'd0);
        tick();
        clear_redir();
        #1;
        check_eq("mis_flag", {31'd0, misalign}, 32'd1);
        check_eq("mis_req", {31'd0, imem_req}, 32'd0);
        check_eq("mis_pc", pc, 32'h8);
        beq = 1'b1; PCbranch = 32'h40;
        #1;
        check_eq("fault_noflush", {31'd0, flush_ifid}, 32'd0);
        tick();
        clear_redir();
        tick();
        check_eq("fault_pc", pc, 32'h8);
        check_eq("fault_sticky", {31'd0, misalign}, 32'd1);
        check_eq("fault_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("fault_clr", {31'd0, misalign}, 32'd0);
        check_eq("fault_clr_pc", pc, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("fault_exit_req", {31'd0, imem_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
